// File: rtl/uart_bus_host.sv
// UART-driven bus initiator: parses 'W'/'R' command packets from the serial line,
// performs one 32-bit access on the device bus and serialises the response back.
module uart_bus_host #(
   parameter int unsigned ClockFrequency = 50_000_000,
   parameter int unsigned BaudRate       = 115_200,
   parameter int unsigned TimeoutCycles  = 1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic        host_req_o,
   input  logic        host_gnt_i,
   output logic [31:0] host_addr_o,
   output logic        host_we_o,
   output logic [3:0]  host_be_o,
   output logic [31:0] host_wdata_o,
   input  logic        host_rvalid_i,
   input  logic [31:0] host_rdata_i,
   output logic        busy_o
);

   localparam int unsigned ClocksPerBaud = ClockFrequency / BaudRate;
   localparam int unsigned BaudW         = $clog2(ClocksPerBaud);
   localparam int unsigned TimeoutW      = $clog2(TimeoutCycles + 1);

   localparam logic [BaudW-1:0]    BaudLast    = BaudW'(ClocksPerBaud - 1);
   localparam logic [BaudW-1:0]    BaudHalf    = BaudW'(ClocksPerBaud / 2);
   localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles);
   localparam logic [7:0]          CharWrite   = 8'h57;
   localparam logic [7:0]          CharRead    = 8'h52;
   localparam logic [7:0]          CharAck     = 8'h06;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {CMD, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP} cmd_state_e;

   rx_state_e         rx_state;
   logic              rx_sync1, rx_sync2, rx_hist;
   logic [BaudW-1:0]  rx_cnt;
   logic [2:0]        rx_bit;
   logic [7:0]        rx_shift;
   logic              rx_byte_valid;
   logic              rx_frame_err;

   cmd_state_e        cmd_state;
   logic              op_write;
   logic [1:0]        byte_idx;
   logic [TimeoutW-1:0] timeout_cnt;
   logic [31:0]       resp_data;
   logic [2:0]        resp_left;

   logic              tx_active;
   logic [BaudW-1:0]  tx_cnt;
   logic [3:0]        tx_idx;
   logic [7:0]        tx_shift;
   logic              tx_done;
   logic              tx_load;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
         rx_hist  <= 1'b1;
      end else begin
         rx_sync1 <= uart_rx_i;
         rx_sync2 <= rx_sync1;
         rx_hist  <= rx_sync2;
      end
   end

   // Receiver: start bit is re-checked at mid-bit so short low glitches are rejected.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_byte_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_byte_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_hist && !rx_sync2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == BaudHalf) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BaudLast) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BaudLast) begin
                  rx_cnt        <= '0;
                  rx_byte_valid <= rx_sync2;
                  rx_frame_err  <= !rx_sync2;
                  rx_state      <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign tx_done = tx_active && (tx_cnt == BaudLast) && (tx_idx == 4'd9);
   // Reloading on the final stop-bit cycle keeps multi-byte responses gap-free.
   assign tx_load = (cmd_state == RESP) && (resp_left != 3'd0) && (!tx_active || tx_done);
   assign busy_o  = (cmd_state != CMD);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_state    <= CMD;
         op_write     <= 1'b0;
         byte_idx     <= '0;
         timeout_cnt  <= '0;
         resp_data    <= '0;
         resp_left    <= '0;
         host_req_o   <= 1'b0;
         host_we_o    <= 1'b0;
         host_be_o    <= '0;
         host_addr_o  <= '0;
         host_wdata_o <= '0;
      end else begin
         case (cmd_state)
            CMD: begin
               byte_idx    <= '0;
               timeout_cnt <= '0;
               if (rx_byte_valid && (rx_shift == CharWrite || rx_shift == CharRead)) begin
                  op_write  <= (rx_shift == CharWrite);
                  cmd_state <= ADDR;
               end
            end
            ADDR, DATA: begin
               if (rx_frame_err) begin
                  cmd_state <= CMD;
               end else if (rx_byte_valid) begin
                  timeout_cnt <= '0;
                  byte_idx    <= byte_idx + 2'd1;
                  if (cmd_state == ADDR) begin
                     host_addr_o[{byte_idx, 3'b000} +: 8] <= rx_shift;
                  end else begin
                     host_wdata_o[{byte_idx, 3'b000} +: 8] <= rx_shift;
                  end
                  if (byte_idx == 2'd3) begin
                     if (cmd_state == ADDR && op_write) begin
                        cmd_state <= DATA;
                     end else begin
                        cmd_state  <= BUS_REQ;
                        host_req_o <= 1'b1;
                        host_be_o  <= 4'hF;
                        host_we_o  <= op_write;
                     end
                  end
               end else if (timeout_cnt == TimeoutLast) begin
                  cmd_state <= CMD;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            BUS_REQ: begin
               if (host_gnt_i) begin
                  host_req_o <= 1'b0;
                  host_be_o  <= '0;
                  if (host_rvalid_i) begin
                     resp_data <= op_write ? {24'd0, CharAck} : host_rdata_i;
                     resp_left <= op_write ? 3'd1 : 3'd4;
                     cmd_state <= RESP;
                  end else begin
                     cmd_state <= BUS_WAIT;
                  end
               end
            end
            BUS_WAIT: begin
               if (host_rvalid_i) begin
                  resp_data <= op_write ? {24'd0, CharAck} : host_rdata_i;
                  resp_left <= op_write ? 3'd1 : 3'd4;
                  cmd_state <= RESP;
               end
            end
            RESP: begin
               if (tx_load) begin
                  resp_data <= {8'd0, resp_data[31:8]};
                  resp_left <= resp_left - 3'd1;
               end else if (tx_done) begin
                  cmd_state <= CMD;
               end
            end
            default: cmd_state <= CMD;
         endcase
      end
   end

   // Transmitter: tx_idx counts completed bit slots, 0 = start, 1..8 = data, 9 = stop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_active <= 1'b0;
         tx_cnt    <= '0;
         tx_idx    <= '0;
         tx_shift  <= '0;
         uart_tx_o <= 1'b1;
      end else if (tx_load) begin
         tx_active <= 1'b1;
         tx_cnt    <= '0;
         tx_idx    <= '0;
         tx_shift  <= resp_data[7:0];
         uart_tx_o <= 1'b0;
      end else if (tx_active) begin
         if (tx_cnt == BaudLast) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 4'd1;
            if (tx_idx == 4'd9) begin
               tx_active <= 1'b0;
               uart_tx_o <= 1'b1;
            end else if (tx_idx == 4'd8) begin
               uart_tx_o <= 1'b1;
            end else begin
               uart_tx_o <= tx_shift[0];
               tx_shift  <= {1'b0, tx_shift[7:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_host.sv
// Scoreboard bench for uart_bus_host: packet-level model predicts bus requests and
// TX bytes; independent monitors decode the bus and serial line and compare.
module tb_uart_bus_host;

   localparam int Cpb = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        uart_rx_i = 1'b1;
   logic        uart_tx_o;
   logic        host_req_o;
   logic        host_gnt_i = 1'b0;
   logic [31:0] host_addr_o;
   logic        host_we_o;
   logic [3:0]  host_be_o;
   logic [31:0] host_wdata_o;
   logic        host_rvalid_i = 1'b0;
   logic [31:0] host_rdata_i = '0;
   logic        busy_o;

   uart_bus_host #(
      .ClockFrequency(64),
      .BaudRate      (4),
      .TimeoutCycles (1000)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .uart_rx_i    (uart_rx_i),
      .uart_tx_o    (uart_tx_o),
      .host_req_o   (host_req_o),
      .host_gnt_i   (host_gnt_i),
      .host_addr_o  (host_addr_o),
      .host_we_o    (host_we_o),
      .host_be_o    (host_be_o),
      .host_wdata_o (host_wdata_o),
      .host_rvalid_i(host_rvalid_i),
      .host_rdata_i (host_rdata_i),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } req_t;

   req_t       exp_req[$];
   logic [7:0] exp_tx[$];
   int         start_q[$];

   int errors = 0;
   int checks = 0;
   int req_count = 0;
   int tx_byte_count = 0;
   int gnt_delay = 1;
   int rv_delay = 1;
   logic [31:0] bus_rdata = '0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Serial driver: one 16-cycle slot per bit; a zero stop bit is followed by idle time.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx_i = 1'b0;
      repeat (Cpb) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = b[i];
         repeat (Cpb) @(negedge clk_i);
      end
      uart_rx_i = stop_bit;
      repeat (Cpb) @(negedge clk_i);
      uart_rx_i = 1'b1;
      if (!stop_bit) repeat (2 * Cpb) @(negedge clk_i);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   // Packet-level model: a write yields one request and an ACK, a read yields the data bytes.
   task automatic apply_write(input logic [31:0] addr, input logic [31:0] data);
      req_t r;
      r.addr = addr; r.we = 1'b1; r.wdata = data;
      exp_req.push_back(r);
      exp_tx.push_back(8'h06);
      send_byte(8'h57, 1'b1);
      send_word(addr);
      send_word(data);
   endtask

   task automatic apply_read(input logic [31:0] addr, input logic [31:0] rdata);
      req_t r;
      r.addr = addr; r.we = 1'b0; r.wdata = '0;
      bus_rdata = rdata;
      exp_req.push_back(r);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
      send_byte(8'h52, 1'b1);
      send_word(addr);
   endtask

   task automatic wait_idle(input string name, output int fall_cyc);
      for (int i = 0; i < 4000; i++) begin
         if (!busy_o) break;
         @(negedge clk_i);
      end
      fall_cyc = cyc;
      check_output(name, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic wait_starts(input string name, input int n);
      for (int i = 0; i < 4000; i++) begin
         if (start_q.size() >= n) break;
         @(negedge clk_i);
      end
      check_output(name, {31'd0, start_q.size() >= n}, 32'd1);
   endtask

   // Bus responder: grant after gnt_delay cycles, rvalid rv_delay cycles after grant.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && host_req_o) begin
            repeat (gnt_delay) @(negedge clk_i);
            host_gnt_i = 1'b1;
            if (rv_delay == 0) begin
               host_rvalid_i = 1'b1;
               host_rdata_i  = bus_rdata;
            end
            @(negedge clk_i);
            host_gnt_i    = 1'b0;
            host_rvalid_i = 1'b0;
            if (rv_delay != 0) begin
               repeat (rv_delay - 1) @(negedge clk_i);
               host_rvalid_i = 1'b1;
               host_rdata_i  = bus_rdata;
               @(negedge clk_i);
               host_rvalid_i = 1'b0;
            end
         end
      end
   end

   // Bus monitor: checks each new request against the scoreboard and its stability.
   initial begin
      logic        prev_req;
      logic        unstable;
      logic [31:0] snap_addr, snap_wdata;
      logic        snap_we;
      req_t        e;
      prev_req = 1'b0;
      unstable = 1'b0;
      snap_addr = '0; snap_wdata = '0; snap_we = 1'b0;
      forever begin
         @(negedge clk_i);
         if (host_req_o === 1'b1 && !prev_req) begin
            req_count++;
            check_output("req_expected", {31'd0, exp_req.size() != 0}, 32'd1);
            if (exp_req.size() != 0) begin
               e = exp_req.pop_front();
               check_output("req_addr", host_addr_o, e.addr);
               check_output("req_we", {31'd0, host_we_o}, {31'd0, e.we});
               check_output("req_be", {28'd0, host_be_o}, 32'hF);
               if (e.we) check_output("req_wdata", host_wdata_o, e.wdata);
            end
            snap_addr = host_addr_o; snap_wdata = host_wdata_o; snap_we = host_we_o;
            unstable = 1'b0;
         end else if (host_req_o === 1'b1) begin
            if (host_addr_o !== snap_addr || host_wdata_o !== snap_wdata ||
                host_we_o !== snap_we || host_be_o !== 4'hF) unstable = 1'b1;
         end else if (prev_req) begin
            check_output("req_stable", {31'd0, unstable}, 32'd0);
         end
         prev_req = (host_req_o === 1'b1);
      end
   end

   // TX monitor: decodes each frame at mid-bit; a reset mid-frame abandons the frame.
   initial begin
      logic [7:0] got;
      logic       start_v, stop_v;
      bit         aborted;
      forever begin
         @(negedge clk_i);
         if (rst_ni && uart_tx_o === 1'b0) begin
            start_q.push_back(cyc);
            aborted = 1'b0;
            got = '0; start_v = 1'b0; stop_v = 1'b0;
            for (int k = 1; k <= 9 * Cpb + Cpb / 2; k++) begin
               @(negedge clk_i);
               if (!rst_ni) begin
                  aborted = 1'b1;
                  break;
               end
               if (k == Cpb / 2) start_v = uart_tx_o;
               else if (k % Cpb == Cpb / 2 && k < 9 * Cpb) got[k / Cpb - 1] = uart_tx_o;
               else if (k == 9 * Cpb + Cpb / 2) stop_v = uart_tx_o;
            end
            if (!aborted) begin
               tx_byte_count++;
               check_output("tx_start_bit", {31'd0, start_v}, 32'd0);
               check_output("tx_stop_bit", {31'd0, stop_v}, 32'd1);
               check_output("tx_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
               if (exp_tx.size() != 0) check_output("tx_byte", {24'd0, got}, {24'd0, exp_tx.pop_front()});
            end
         end
      end
   end

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int f;
      int r0, t0;
      logic [31:0] a, d;

      #1 rst_ni = 1'b0;
      repeat (4) @(negedge clk_i);
      check_output("rst_tx", {31'd0, uart_tx_o}, 32'd1);
      check_output("rst_req", {31'd0, host_req_o}, 32'd0);
      check_output("rst_we", {31'd0, host_we_o}, 32'd0);
      check_output("rst_be", {28'd0, host_be_o}, 32'd0);
      check_output("rst_addr", host_addr_o, 32'd0);
      check_output("rst_wdata", host_wdata_o, 32'd0);
      check_output("rst_busy", {31'd0, busy_o}, 32'd0);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);

      gnt_delay = 3; rv_delay = 2;
      start_q.delete();
      apply_write(32'h8000_0010, 32'hDEAD_BEEF);
      wait_idle("wr_idle", f);
      check_output("wr_tx_count", start_q.size(), 1);
      if (start_q.size() == 1) check_output("wr_busy_fall", f - start_q[0], 10 * Cpb);

      gnt_delay = 1; rv_delay = 1;
      start_q.delete();
      apply_read(32'h0000_0004, 32'h1234_5678);
      wait_idle("rd_idle", f);
      check_output("rd_tx_count", start_q.size(), 4);
      for (int i = 1; i < start_q.size(); i++) check_output("rd_gap", start_q[i] - start_q[i-1], 10 * Cpb);

      r0 = req_count; t0 = tx_byte_count;
      uart_rx_i = 1'b0;
      repeat (4) @(negedge clk_i);
      uart_rx_i = 1'b1;
      repeat (30) @(negedge clk_i);
      check_output("glitch_busy", {31'd0, busy_o}, 32'd0);
      check_output("glitch_tx", tx_byte_count, t0);
      apply_read($urandom, $urandom);
      wait_idle("glitch_next_idle", f);
      check_output("glitch_next_req", req_count, r0 + 1);

      r0 = req_count;
      send_byte(8'h57, 1'b0);
      check_output("fe_cmd_busy", {31'd0, busy_o}, 32'd0);
      send_byte(8'h52, 1'b1);
      check_output("fe_hdr_busy", {31'd0, busy_o}, 32'd1);
      send_byte(8'h00, 1'b0);
      check_output("fe_abort_busy", {31'd0, busy_o}, 32'd0);
      repeat (50) @(negedge clk_i);
      check_output("fe_no_req", req_count, r0);

      r0 = req_count; t0 = tx_byte_count;
      send_byte(8'h57, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      repeat (500) @(negedge clk_i);
      check_output("to_busy_early", {31'd0, busy_o}, 32'd1);
      repeat (600) @(negedge clk_i);
      check_output("to_busy_late", {31'd0, busy_o}, 32'd0);
      check_output("to_no_req", req_count, r0);
      check_output("to_no_tx", tx_byte_count, t0);
      apply_read($urandom, $urandom);
      wait_idle("to_next_idle", f);
      check_output("to_next_req", req_count, r0 + 1);

      t0 = tx_byte_count;
      send_byte(8'hAA, 1'b1);
      repeat (200) @(negedge clk_i);
      check_output("junk_cmd_busy", {31'd0, busy_o}, 32'd0);
      check_output("junk_cmd_tx", tx_byte_count, t0);

      gnt_delay = 50; rv_delay = 3;
      r0 = req_count;
      start_q.delete();
      apply_read($urandom, $urandom);
      repeat (25) @(negedge clk_i);
      check_output("stall_req_held", {31'd0, host_req_o}, 32'd1);
      wait_starts("stall_resp_start", 1);
      send_byte(8'h57, 1'b1);
      send_byte(8'h52, 1'b1);
      wait_idle("stall_idle", f);
      check_output("stall_tx_count", start_q.size(), 4);
      if (start_q.size() == 4) check_output("resp_junk_fall", f - start_q[3], 10 * Cpb);
      check_output("stall_req_count", req_count, r0 + 1);

      gnt_delay = 1; rv_delay = 0;
      start_q.delete();
      apply_read($urandom, 32'hCAFE_F00D);
      wait_starts("rst_wait_byte2", 2);
      repeat (40) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check_output("rst_mid_tx", {31'd0, uart_tx_o}, 32'd1);
      check_output("rst_mid_req", {31'd0, host_req_o}, 32'd0);
      check_output("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      exp_tx.delete();
      repeat (5) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      t0 = tx_byte_count;
      apply_write($urandom, $urandom);
      wait_idle("rst_next_idle", f);
      check_output("rst_next_tx", tx_byte_count, t0 + 1);

      for (int n = 0; n < 6; n++) begin
         gnt_delay = $urandom_range(0, 6);
         rv_delay  = $urandom_range(0, 3);
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 1) == 1) apply_write(a, d);
         else apply_read(a, d);
         wait_idle("rand_idle", f);
      end

      repeat (20) @(negedge clk_i);
      check_output("end_req_queue", exp_req.size(), 0);
      check_output("end_tx_queue", exp_tx.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
